spi_master: RTL
===============

Name: spi_master

Overview:
- Initiator end of the team's 8-bit SPI link.
- Drives ss (active-high frame), spi_clk and mosi toward an spi_slave-style responder, and captures miso.
- Runs on system clock sclk and divides it to produce spi_clk.
- Presents a simple start/busy/done handshake to the local controller.

Parameters:
- DATA_W, 8, transfer width in bits, MSB first.
- CLK_DIV, 4, sclk cycles per spi_clk half-period; legal range ≥1.

Ports:
- sclk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request transfer; sampled only while busy=0.
- tx_data  in  DATA_W  word to send; captured on start acceptance.
- rx_data  out  DATA_W  last received word; updated with done.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse at end of transfer.
- ss  out  1  frame select, active-high.
- spi_clk  out  1  serial clock, idle low.
- mosi  out  1  serial data to slave.
- miso  in  1  serial data from slave.

Behaviour:
- Reset (async, any state): ss=0, spi_clk=0, mosi=0, busy=0, done=0, rx_data=0.
  - State returns to IDLE; divider, bit counter and shift registers clear.
  - Reset mid-frame aborts the transfer with no done pulse.
- Protocol contract with the slave:
  - Slave shifts mosi in, and updates miso, on rising spi_clk while ss=1.
  - The master therefore changes mosi only while spi_clk is low.
  - The master samples miso on falling spi_clk.
- Divider: a half-period counter counts 0..CLK_DIV-1. tick = (count==CLK_DIV-1); the counter is held at 0 in IDLE.
- FSM:
  - IDLE: ss=0, spi_clk=0, mosi=0.
    - On start=1, load tx shift register with tx_data and set mosi=tx_data[DATA_W-1], ss=1, busy=1, bit_cnt=0; go to LEAD.
  - LEAD: on tick, spi_clk=1; go to HIGH. Gives one half-period of ss/mosi setup.
  - HIGH: on tick, spi_clk=0 and shift miso into rx shift register LSB.
    - If bit_cnt==DATA_W-1, go to TRAIL.
    - Otherwise bit_cnt++, shift tx left, set mosi to the new MSB, go to LOW.
  - LOW: on tick, spi_clk=1; go to HIGH.
  - TRAIL: mosi holds the last bit.
    - On tick: ss=0, mosi=0, rx_data=rx shift register, busy=0, done=1 for one cycle; go to IDLE.
- Latency: start sampled at edge 0 → ss high after edge 0; first spi_clk rise after edge CLK_DIV; done high after edge (2·DATA_W+1)·CLK_DIV, i.e. edge 68 for the defaults.
- Exactly DATA_W rising and DATA_W falling spi_clk edges per frame; spi_clk duty is 50%.
- start while busy=1 is ignored. tx_data changes after acceptance have no effect.
- Back-to-back transfers: busy=0 in the done cycle, so start at the next edge is accepted. ss therefore stays low for at least one sclk cycle between frames.
- rx_data is stable between done pulses and is never partially updated.
- miso is ignored outside HIGH→LOW transitions.

Decomposition:
- spi_pkg:
  - Holds the FSM state localparams (IDLE, LEAD, HIGH, LOW, TRAIL) and the DATA_W default.
  - Shared with spi_slave benches.
- Sub-module spi_clk_div:
  - Parameter CLK_DIV; inputs sclk, rst, en; output tick.
  - The only natural split.

Test Plan:
- Loopback to slave model, slave preloaded 0x3C, tx_data=0xA5, CLK_DIV=4 → rx_data=0x3C and slave data_out=0xA5; done after exactly 68 cycles; 8 spi_clk rises observed.
- Edge check: mosi never changes while spi_clk=1; ss high ≥CLK_DIV cycles before the first rise and after the last fall.
- start pulsed at cycles 10 and 30 of a frame, tx_data=0xFF then 0x00 → both ignored; frame completes with the original 0x81 payload.
- Back-to-back: start held high with tx_data 0x12 then 0x34 → two frames, two done pulses 69 cycles apart; slave receives 0x12 then 0x34.
- rst asserted during bit 4 → same cycle ss=0, spi_clk=0, busy=0, rx_data=0; no done pulse; next transfer of 0x5A completes normally.
- CLK_DIV=1 build → done after 17 cycles; rx and tx data correct.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the 8-bit SPI link: FSM state codes and default word width.
// Imported by spi_master and reused by spi_slave benches.
package spi_pkg;

  localparam int DATA_W_DEFAULT = 8;

  typedef logic [2:0] state_t;

  localparam state_t IDLE  = 3'd0;
  localparam state_t LEAD  = 3'd1;
  localparam state_t HIGH  = 3'd2;
  localparam state_t LOW   = 3'd3;
  localparam state_t TRAIL = 3'd4;

endpackage

// File: rtl/spi_master_clk_div.sv
// Half-period divider for spi_clk: tick marks the last sclk cycle of each half-period.
// The counter is held at zero while en is low so every frame starts on a clean boundary.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic sclk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] count_reg;

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (!en || tick) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign tick = en && (count_reg == CW'(CLK_DIV - 1));

endmodule

// File: rtl/spi_master.sv
// SPI initiator: MSB-first DATA_W-bit frames, spi_clk idle low, mosi launched while
// spi_clk is low and miso sampled on the falling edge. All outputs are registered.
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int CLK_DIV = 4
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              ss,
  output logic              spi_clk,
  output logic              mosi,
  input  logic              miso
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] tx_reg, tx_next;
  logic [DATA_W-1:0] rx_reg, rx_next;
  logic [DATA_W-1:0] rx_data_reg, rx_data_next;
  logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic              done_reg, done_next;
  logic              ss_reg, ss_next;
  logic              busy_reg, busy_next;
  logic              spi_clk_reg, spi_clk_next;
  logic              mosi_reg, mosi_next;
  logic              tick;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .sclk (sclk),
    .rst  (rst),
    .en   (state_reg != IDLE),
    .tick (tick)
  );

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      tx_reg      <= '0;
      rx_reg      <= '0;
      rx_data_reg <= '0;
      bit_cnt_reg <= '0;
      done_reg    <= 1'b0;
      ss_reg      <= 1'b0;
      busy_reg    <= 1'b0;
      spi_clk_reg <= 1'b0;
      mosi_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      tx_reg      <= tx_next;
      rx_reg      <= rx_next;
      rx_data_reg <= rx_data_next;
      bit_cnt_reg <= bit_cnt_next;
      done_reg    <= done_next;
      ss_reg      <= ss_next;
      busy_reg    <= busy_next;
      spi_clk_reg <= spi_clk_next;
      mosi_reg    <= mosi_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    tx_next      = tx_reg;
    rx_next      = rx_reg;
    rx_data_next = rx_data_reg;
    bit_cnt_next = bit_cnt_reg;
    done_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          tx_next      = tx_data;
          rx_next      = '0;
          bit_cnt_next = '0;
          state_next   = LEAD;
        end
      end
      LEAD: if (tick) state_next = HIGH;
      HIGH: begin
        // Falling spi_clk: slave updated miso a full half-period ago.
        if (tick) begin
          rx_next = {rx_reg[DATA_W-2:0], miso};
          if (bit_cnt_reg == CNT_W'(DATA_W - 1)) begin
            state_next = TRAIL;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
            tx_next      = {tx_reg[DATA_W-2:0], 1'b0};
            state_next   = LOW;
          end
        end
      end
      LOW: if (tick) state_next = HIGH;
      TRAIL: begin
        if (tick) begin
          rx_data_next = rx_reg;
          done_next    = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pin values follow directly from the state being entered, so they change with it.
  always_comb begin
    ss_next      = (state_next != IDLE);
    busy_next    = (state_next != IDLE);
    spi_clk_next = (state_next == HIGH);
    mosi_next    = (state_next != IDLE) ? tx_next[DATA_W-1] : 1'b0;
  end

  assign rx_data = rx_data_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign ss      = ss_reg;
  assign spi_clk = spi_clk_reg;
  assign mosi    = mosi_reg;

endmodule
